// File: rtl/trace_pkg.sv
// Shared sizing helpers and entry field offsets for the memory trace recorder.
// Entry layout is {ts (TRACE_TIMESTAMP_EN only), ch_id, addr}.
package trace_pkg;

  localparam int MAX_CH   = 8;
  localparam int ADDR_OFF = 0;

`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  function automatic int calc_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int calc_entry_w(input int num_ch, input int addr_w, input int ts_w);
    return calc_ch_w(num_ch) + addr_w + (TS_EN ? ts_w : 0);
  endfunction

  function automatic int ch_off(input int addr_w);
    return ADDR_OFF + addr_w;
  endfunction

  function automatic int ts_off(input int num_ch, input int addr_w);
    return ch_off(addr_w) + calc_ch_w(num_ch);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO for trace entries; accepts a push while full when a pop
// happens in the same cycle. Output data reads as zero while empty.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [AW-1:0]          r_wr;
  logic [AW-1:0]          r_rd;
  logic [$clog2(DEPTH):0] r_level;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + ($clog2(DEPTH)+1)'(1);
        2'b01:   r_level <= r_level - ($clog2(DEPTH)+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  // DEPTH is a power of two, so the level MSB alone marks full.
  assign o_full  = r_level[AW];
  assign o_valid = |r_level;
  assign o_data  = o_valid ? r_mem[r_rd] : '0;
  assign o_level = r_level;

endmodule

// File: rtl/mem_trace_recorder.sv
// Multi-channel memory-access trace recorder: per-channel pending regs, round-robin
// push into a show-ahead FIFO, saturating drop counters. Macro: TRACE_TIMESTAMP_EN.
module mem_trace_recorder
  import trace_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int DROP_W = 8
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [NUM_CH-1:0]                             ch_en_i,
  input  logic [NUM_CH-1:0]                             ch_valid_i,
  input  logic [NUM_CH*ADDR_W-1:0]                      ch_addr_i,
  output logic                                          trace_valid_o,
  input  logic                                          trace_ready_i,
  output logic [calc_entry_w(NUM_CH, ADDR_W, TS_W)-1:0] trace_data_o,
  output logic [$clog2(DEPTH):0]                        fifo_level_o,
  output logic [NUM_CH*DROP_W-1:0]                      drop_cnt_o
);

  localparam int CH_W    = calc_ch_w(NUM_CH);
  localparam int ENTRY_W = calc_entry_w(NUM_CH, ADDR_W, TS_W);
  localparam int CH_OFF  = ch_off(ADDR_W);

  logic [ADDR_W-1:0]  w_addr [NUM_CH];
  logic [ADDR_W-1:0]  r_pend_addr [NUM_CH];
  logic [NUM_CH-1:0]  r_pend_vld;
  logic [DROP_W-1:0]  r_drop [NUM_CH];
  logic [CH_W-1:0]    r_rr;
  logic [NUM_CH-1:0]  w_ev;
  logic [NUM_CH-1:0]  w_gnt_oh;
  logic [NUM_CH-1:0]  w_gnt;
  logic [NUM_CH-1:0]  w_load;
  logic               w_gnt_vld;
  logic [CH_W-1:0]    w_gnt_idx;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic [ENTRY_W-1:0] w_push_data;

`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_OFF = ts_off(NUM_CH, ADDR_W);
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_pend_ts [NUM_CH];

  always_ff @(posedge clk_i) begin
    if (rst_i) r_ts <= '0;
    else       r_ts <= r_ts + TS_W'(1);
  end
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_addr[g]                         = ch_addr_i[g*ADDR_W +: ADDR_W];
    assign drop_cnt_o[g*DROP_W +: DROP_W]    = r_drop[g];
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_gnt_oh  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      int k;
      k = (int'(r_rr) + i) % NUM_CH;
      if (!w_gnt_vld && r_pend_vld[k]) begin
        w_gnt_vld   = 1'b1;
        w_gnt_idx   = CH_W'(k);
        w_gnt_oh[k] = 1'b1;
      end
    end
  end

  assign w_pop  = trace_valid_o & trace_ready_i;
  assign w_push = w_gnt_vld & (~w_full | w_pop);
  assign w_ev   = ch_en_i & ch_valid_i;
  assign w_gnt  = w_gnt_oh & {NUM_CH{w_push}};
  assign w_load = w_ev & (~r_pend_vld | w_gnt);

  always_comb begin
    w_push_data                         = '0;
    w_push_data[ADDR_OFF +: ADDR_W]     = r_pend_addr[w_gnt_idx];
    w_push_data[CH_OFF +: CH_W]         = w_gnt_idx;
`ifdef TRACE_TIMESTAMP_EN
    w_push_data[TS_OFF +: TS_W]         = r_pend_ts[w_gnt_idx];
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend_vld <= '0;
      r_rr       <= CH_W'(NUM_CH - 1);
      for (int k = 0; k < NUM_CH; k++) r_drop[k] <= '0;
    end else begin
      if (w_push) r_rr <= w_gnt_idx;
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_load[k])     r_pend_vld[k] <= 1'b1;
        else if (w_gnt[k]) r_pend_vld[k] <= 1'b0;
        // An event arriving while the slot stays occupied is lost.
        if (w_ev[k] && r_pend_vld[k] && !w_gnt[k] && (r_drop[k] != '1))
          r_drop[k] <= r_drop[k] + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_load[k]) begin
        r_pend_addr[k] <= w_addr[k];
`ifdef TRACE_TIMESTAMP_EN
        r_pend_ts[k]   <= r_ts;
`endif
      end
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_valid (trace_valid_o),
    .o_data  (trace_data_o),
    .o_level (fifo_level_o),
    .o_full  (w_full)
  );

endmodule

// File: tb/tb_mem_trace_recorder.sv
// Directed self-checking bench for mem_trace_recorder (NUM_CH=2, DEPTH=16, DROP_W=8, TS_W=4).
module tb_mem_trace_recorder;

`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = 4 + 1 + 32;
`else
  localparam int ENTRY_W = 1 + 32;
`endif

  logic               clk;
  logic               rst;
  logic [1:0]         ch_en;
  logic [1:0]         ch_valid;
  logic [63:0]        ch_addr;
  logic               trace_valid;
  logic               trace_ready;
  logic [ENTRY_W-1:0] trace_data;
  logic [4:0]         fifo_level;
  logic [15:0]        drop_cnt;

  int n_pass = 0;
  int n_chk  = 0;

  mem_trace_recorder #(
    .NUM_CH (2),
    .ADDR_W (32),
    .DEPTH  (16),
    .TS_W   (4),
    .DROP_W (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ch_en_i       (ch_en),
    .ch_valid_i    (ch_valid),
    .ch_addr_i     (ch_addr),
    .trace_valid_o (trace_valid),
    .trace_ready_i (trace_ready),
    .trace_data_o  (trace_data),
    .fifo_level_o  (fifo_level),
    .drop_cnt_o    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ch_valid = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst         = 1'b1;
    ch_en       = 2'b11;
    ch_valid    = 2'b00;
    ch_addr     = '0;
    trace_ready = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_data",  64'(trace_data),  64'd0);
    chk("rst_level", 64'(fifo_level),  64'd0);
    chk("rst_drop",  64'(drop_cnt),    64'd0);

    // Single event on ch0
    ch_valid = 2'b01; ch_addr[31:0] = 32'h10;
    step();
    ch_valid = 2'b00;
    chk("single_not_yet", 64'(trace_valid), 64'd0);
    step();
    chk("single_valid", 64'(trace_valid), 64'd1);
    chk("single_data",  64'(trace_data[32:0]), {31'd0, 1'b0, 32'h10});
    chk("single_level", 64'(fifo_level), 64'd1);
    step();
    chk("single_drained", 64'(fifo_level), 64'd0);
    chk("single_empty",   64'(trace_valid), 64'd0);

    // Collision, arbitration order from reset
    do_reset();
    ch_valid = 2'b11; ch_addr = {32'h400, 32'h20};
    step();
    ch_valid = 2'b00;
    step();
    chk("coll_first",  64'(trace_data[32:0]), {31'd0, 1'b0, 32'h20});
    chk("coll_level1", 64'(fifo_level), 64'd1);
    step();
    chk("coll_second", 64'(trace_data[32:0]), {31'd0, 1'b1, 32'h400});
    chk("coll_level2", 64'(fifo_level), 64'd1);
    step();
    chk("coll_empty", 64'(trace_valid), 64'd0);
    chk("coll_drops", 64'(drop_cnt), 64'd0);

    // Full FIFO: 20 back-to-back ch1 events with the sink stalled
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ch_valid = 2'b10; ch_addr[63:32] = 32'h1000 + 32'(i);
      step();
    end
    ch_valid = 2'b00;
    chk("full_level", 64'(fifo_level), 64'd16);
    chk("full_drop1", 64'(drop_cnt[15:8]), 64'd3);
    chk("full_drop0", 64'(drop_cnt[7:0]), 64'd0);
    trace_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("drain_%0d", i), 64'(trace_data[32:0]), {31'd0, 1'b1, 32'h1000 + 32'(i)});
      step();
    end
    chk("drain_level", 64'(fifo_level), 64'd0);

    // Drop-counter saturation on ch0
    do_reset();
    trace_ready = 1'b0;
    ch_valid = 2'b01; ch_addr[31:0] = 32'h77;
    for (int i = 0; i < 17 + 254; i++) step();
    chk("sat_254", 64'(drop_cnt[7:0]), 64'd254);
    for (int i = 0; i < 46; i++) step();
    ch_valid = 2'b00;
    chk("sat_255",   64'(drop_cnt[7:0]),  64'd255);
    chk("sat_other", 64'(drop_cnt[15:8]), 64'd0);

    // Reset mid-run with five buffered entries
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ch_valid = 2'b01; ch_addr[31:0] = 32'h200 + 32'(i);
      step();
    end
    ch_valid = 2'b00;
    step();
    chk("mid_level5", 64'(fifo_level), 64'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_level0", 64'(fifo_level),  64'd0);
    chk("mid_valid0", 64'(trace_valid), 64'd0);
    chk("mid_drops0", 64'(drop_cnt),    64'd0);
    trace_ready = 1'b1;
    ch_valid = 2'b10; ch_addr[63:32] = 32'hABC;
    step();
    ch_valid = 2'b00;
    step();
    chk("mid_next_valid", 64'(trace_valid), 64'd1);
    chk("mid_next_data",  64'(trace_data[32:0]), {31'd0, 1'b1, 32'hABC});
    step();

`ifdef TRACE_TIMESTAMP_EN
    // Timestamp capture across a 4-bit wrap
    do_reset();
    trace_ready = 1'b1;
    for (int i = 0; i < 14; i++) step();
    ch_valid = 2'b01; ch_addr[31:0] = 32'h50;
    step();
    ch_valid = 2'b00;
    step();
    chk("ts_e",      64'(trace_data[36:33]), 64'hE);
    chk("ts_e_addr", 64'(trace_data[32:0]), {31'd0, 1'b0, 32'h50});
    step();
    ch_valid = 2'b01; ch_addr[31:0] = 32'h54;
    step();
    ch_valid = 2'b00;
    step();
    chk("ts_1",      64'(trace_data[36:33]), 64'h1);
    chk("ts_1_addr", 64'(trace_data[32:0]), {31'd0, 1'b0, 32'h54});
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
